// File: rtl/vend_pkg.sv
// Shared definitions for the parametrised vending controller: coin codes,
// coin value/legality helpers and the controller state encoding.
package vend_pkg;

  localparam logic [1:0] COIN_NICKEL  = 2'd0;
  localparam logic [1:0] COIN_DIME    = 2'd1;
  localparam logic [1:0] COIN_QUARTER = 2'd2;
  localparam logic [1:0] COIN_DOLLAR  = 2'd3;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    CREDIT   = 2'd1,
    DISPENSE = 2'd2,
    CHANGE   = 2'd3
  } state_t;

  function automatic logic [6:0] coin_value(input logic [1:0] code);
    case (code)
      COIN_NICKEL:  return 7'd5;
      COIN_DIME:    return 7'd10;
      COIN_QUARTER: return 7'd25;
      default:      return 7'd100;
    endcase
  endfunction

  // Callers zero-extend their amount so the check works for any AMT_W.
  function automatic logic is_legal_coin(input logic [31:0] amt);
    return (amt == 32'd5) || (amt == 32'd10) || (amt == 32'd25) || (amt == 32'd100);
  endfunction

endpackage

// File: rtl/change_dispenser.sv
// Greedy change picker with the hopper handshake. The offered coin is a pure
// function of the remaining credit, so it is stable while the hopper stalls.
module change_dispenser
  import vend_pkg::*;
#(
  parameter int AMT_W = 8
) (
  input  logic [AMT_W-1:0] credit,
  input  logic             chg_ready,
  input  logic             active,
  output logic             chg_valid,
  output logic [1:0]       chg_coin,
  output logic [AMT_W-1:0] dec
);

  logic [31:0] credit_ext;

  assign credit_ext = 32'(credit);

  always_comb begin
    chg_coin = COIN_NICKEL;
    if (credit_ext >= 32'd100)     chg_coin = COIN_DOLLAR;
    else if (credit_ext >= 32'd25) chg_coin = COIN_QUARTER;
    else if (credit_ext >= 32'd10) chg_coin = COIN_DIME;
  end

  assign chg_valid = active;
  assign dec       = (active && chg_ready) ? AMT_W'(coin_value(chg_coin)) : '0;

endmodule

// File: rtl/vend_ctrl_param.sv
// Parametrised vending controller: coin acceptance with saturation, item
// selection against a price table, and greedy change/refund over valid/ready.
//
// Change handshake: chg_valid offers chg_coin; a coin is transferred on every
// cycle where chg_valid && chg_ready at the rising clock edge. While chg_ready
// is low, chg_valid stays high and chg_coin does not change.
module vend_ctrl_param
  import vend_pkg::*;
#(
  parameter int N_ITEMS    = 8,
  parameter int SEL_W      = 3,
  parameter int AMT_W      = 8,
  parameter int MAX_CREDIT = 255,
  parameter logic [N_ITEMS*AMT_W-1:0] PRICES =
    {8'd50, 8'd45, 8'd40, 8'd35, 8'd30, 8'd25, 8'd20, 8'd15}
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             coin_valid,
  input  logic [AMT_W-1:0] coin_amt,
  input  logic             sel_valid,
  input  logic [SEL_W-1:0] sel,
  input  logic             cancel,
  input  logic             chg_ready,
  output logic [AMT_W-1:0] credit,
  output logic             coin_reject,
  output logic             sel_err,
  output logic             dispense_valid,
  output logic [SEL_W-1:0] item_dispensed,
  output logic             chg_valid,
  output logic [1:0]       chg_coin,
  output logic             busy,
  output logic [1:0]       state
);

  localparam logic [AMT_W:0] MAX_SUM = (AMT_W+1)'(MAX_CREDIT);

  state_t           state_q, state_d;
  logic [AMT_W-1:0] credit_q, credit_d;
  logic             coin_reject_q, coin_reject_d;
  logic             sel_err_q, sel_err_d;
  logic             dispense_q, dispense_d;
  logic [SEL_W-1:0] item_q, item_d;

  logic [AMT_W:0]   coin_sum;
  logic             coin_ok;
  logic [AMT_W-1:0] price;
  logic             sel_in_range;
  logic [AMT_W-1:0] chg_dec;

  change_dispenser #(.AMT_W(AMT_W)) u_change (
    .credit    (credit_q),
    .chg_ready (chg_ready),
    .active    (state_q == CHANGE),
    .chg_valid (chg_valid),
    .chg_coin  (chg_coin),
    .dec       (chg_dec)
  );

  // Loop lookup keeps out-of-range indices from reading past the table.
  always_comb begin
    price        = '0;
    sel_in_range = 1'b0;
    for (int i = 0; i < N_ITEMS; i++) begin
      if (32'(sel) == 32'(i)) begin
        price        = PRICES[i*AMT_W +: AMT_W];
        sel_in_range = 1'b1;
      end
    end
  end

  assign coin_sum = {1'b0, credit_q} + {1'b0, coin_amt};
  assign coin_ok  = is_legal_coin(32'(coin_amt)) && (coin_sum <= MAX_SUM);

  always_comb begin
    state_d       = state_q;
    credit_d      = credit_q;
    coin_reject_d = 1'b0;
    sel_err_d     = 1'b0;
    dispense_d    = 1'b0;
    item_d        = '0;
    case (state_q)
      IDLE, CREDIT: begin
        // cancel beats selection beats coin; a losing coin is rejected
        if (cancel && state_q == CREDIT) begin
          state_d       = CHANGE;
          coin_reject_d = coin_valid;
        end else if (sel_valid) begin
          coin_reject_d = coin_valid;
          if (!sel_in_range || credit_q < price) begin
            sel_err_d = 1'b1;
          end else begin
            state_d    = DISPENSE;
            credit_d   = credit_q - price;
            dispense_d = 1'b1;
            item_d     = sel;
          end
        end else if (coin_valid) begin
          if (coin_ok) begin
            credit_d = coin_sum[AMT_W-1:0];
            state_d  = CREDIT;
          end else begin
            coin_reject_d = 1'b1;
          end
        end
      end
      DISPENSE: begin
        coin_reject_d = coin_valid;
        state_d       = (credit_q != '0) ? CHANGE : IDLE;
      end
      default: begin
        coin_reject_d = coin_valid;
        credit_d      = credit_q - chg_dec;
        if (credit_d == '0) state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= IDLE;
      credit_q      <= '0;
      coin_reject_q <= 1'b0;
      sel_err_q     <= 1'b0;
      dispense_q    <= 1'b0;
      item_q        <= '0;
    end else begin
      state_q       <= state_d;
      credit_q      <= credit_d;
      coin_reject_q <= coin_reject_d;
      sel_err_q     <= sel_err_d;
      dispense_q    <= dispense_d;
      item_q        <= item_d;
    end
  end

  assign credit         = credit_q;
  assign coin_reject    = coin_reject_q;
  assign sel_err        = sel_err_q;
  assign dispense_valid = dispense_q;
  assign item_dispensed = item_q;
  assign busy           = (state_q == DISPENSE) || (state_q == CHANGE);
  assign state          = state_q;

  for (genvar gi = 0; gi < N_ITEMS; gi++) begin : g_price_chk
    price_mult5: assert property (@(posedge clk)
      (PRICES[gi*AMT_W +: AMT_W] != '0) && ((PRICES[gi*AMT_W +: AMT_W] % AMT_W'(5)) == '0));
  end

  credit_mult5: assert property (@(posedge clk) disable iff (rst)
    (credit_q % AMT_W'(5)) == '0);

  chg_coin_stable: assert property (@(posedge clk) disable iff (rst)
    (chg_valid && !chg_ready) |=> $stable(chg_coin));

endmodule

// File: tb/tb_vend_ctrl_param.sv
// Self-checking bench for vend_ctrl_param: directed scenarios plus randomized
// purchases, with expected change coins queued and compared per handshake.
module tb_vend_ctrl_param;

  logic       clk;
  logic       rst;
  logic       coin_valid;
  logic [7:0] coin_amt;
  logic       sel_valid;
  logic [3:0] sel;
  logic       cancel;
  logic       chg_ready;
  logic [7:0] credit;
  logic       coin_reject;
  logic       sel_err;
  logic       dispense_valid;
  logic [3:0] item_dispensed;
  logic       chg_valid;
  logic [1:0] chg_coin;
  logic       busy;
  logic [1:0] state;

  int n_cmp = 0;
  int n_bad = 0;
  logic [1:0] exp_q[$];

  vend_ctrl_param #(
    .N_ITEMS(8), .SEL_W(4), .AMT_W(8), .MAX_CREDIT(255),
    .PRICES({8'd50, 8'd45, 8'd40, 8'd35, 8'd30, 8'd25, 8'd20, 8'd15})
  ) dut (
    .clk(clk), .rst(rst), .coin_valid(coin_valid), .coin_amt(coin_amt),
    .sel_valid(sel_valid), .sel(sel), .cancel(cancel), .chg_ready(chg_ready),
    .credit(credit), .coin_reject(coin_reject), .sel_err(sel_err),
    .dispense_valid(dispense_valid), .item_dispensed(item_dispensed),
    .chg_valid(chg_valid), .chg_coin(chg_coin), .busy(busy), .state(state)
  );

  // clock / watchdog
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout required summary before 500us");
    $fatal(1, "watchdog expired");
  end

  // drivers: inputs change and outputs are sampled 1 time unit after the edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic put_coin(input int amt);
    coin_valid = 1'b1;
    coin_amt   = 8'(amt);
    tick();
    coin_valid = 1'b0;
    coin_amt   = '0;
  endtask

  task automatic press(input int idx);
    sel_valid = 1'b1;
    sel       = 4'(idx);
    tick();
    sel_valid = 1'b0;
    sel       = '0;
  endtask

  task automatic do_cancel();
    cancel = 1'b1;
    tick();
    cancel = 1'b0;
  endtask

  // greedy reference for the refund sequence
  task automatic push_greedy(input int amount);
    int c;
    c = amount;
    while (c > 0) begin
      if (c >= 100)     begin exp_q.push_back(2'd3); c -= 100; end
      else if (c >= 25) begin exp_q.push_back(2'd2); c -= 25;  end
      else if (c >= 10) begin exp_q.push_back(2'd1); c -= 10;  end
      else              begin exp_q.push_back(2'd0); c -= 5;   end
    end
  endtask

  // scoreboard: pop one expected coin per offered coin, ready held high
  task automatic drain_change(input string name, input int budget);
    int cyc;
    logic [1:0] exp;
    cyc = 0;
    chg_ready = 1'b1;
    while (exp_q.size() > 0 && cyc < budget) begin
      if (chg_valid) begin
        exp = exp_q.pop_front();
        n_cmp++;
        if (chg_coin !== exp) begin
          n_bad++;
          $display("FAIL %s_coin: got %0d expected %0d", name, chg_coin, exp);
        end
      end
      tick();
      cyc++;
    end
    chg_ready = 1'b0;
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_bad++;
      $display("FAIL %s_timeout: got %0d coins left expected 0", name, exp_q.size());
      exp_q.delete();
    end
    n_cmp++;
    if (state !== 2'd0 || credit !== 8'd0 || chg_valid !== 1'b0) begin
      n_bad++;
      $display("FAIL %s_end: got state=%0d credit=%0d chg_valid=%0d expected 0/0/0",
               name, state, credit, chg_valid);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    n_cmp++;
    if (state !== 2'd0 || credit !== 8'd0) begin
      n_bad++;
      $display("FAIL reset_state: got state=%0d credit=%0d expected 0/0", state, credit);
    end
    n_cmp++;
    if ({coin_reject, sel_err, dispense_valid, chg_valid, busy} !== 5'b0) begin
      n_bad++;
      $display("FAIL reset_flags: got %b expected 00000",
               {coin_reject, sel_err, dispense_valid, chg_valid, busy});
    end
    n_cmp++;
    if (chg_coin !== 2'd0 || item_dispensed !== 4'd0) begin
      n_bad++;
      $display("FAIL reset_data: got coin=%0d item=%0d expected 0/0", chg_coin, item_dispensed);
    end
  endtask

  task automatic test_dispense();
    put_coin(25);
    n_cmp++;
    if (credit !== 8'd25 || state !== 2'd1) begin
      n_bad++;
      $display("FAIL disp_coin1: got credit=%0d state=%0d expected 25/1", credit, state);
    end
    put_coin(25);
    n_cmp++;
    if (credit !== 8'd50) begin
      n_bad++;
      $display("FAIL disp_coin2: got credit=%0d expected 50", credit);
    end
    press(3);
    n_cmp++;
    if (dispense_valid !== 1'b1 || item_dispensed !== 4'd3 || credit !== 8'd20 ||
        state !== 2'd2 || busy !== 1'b1) begin
      n_bad++;
      $display("FAIL disp_pulse: got dv=%0d item=%0d credit=%0d state=%0d busy=%0d expected 1/3/20/2/1",
               dispense_valid, item_dispensed, credit, state, busy);
    end
    tick();
    n_cmp++;
    if (dispense_valid !== 1'b0 || item_dispensed !== 4'd0 || chg_valid !== 1'b1 || state !== 2'd3) begin
      n_bad++;
      $display("FAIL disp_after: got dv=%0d item=%0d chg_valid=%0d state=%0d expected 0/0/1/3",
               dispense_valid, item_dispensed, chg_valid, state);
    end
    exp_q.push_back(2'd1);
    exp_q.push_back(2'd1);
    drain_change("disp_change", 10);
  endtask

  task automatic test_sel_err();
    put_coin(5);
    put_coin(10);
    press(6);
    n_cmp++;
    if (sel_err !== 1'b1 || credit !== 8'd15 || state !== 2'd1 || dispense_valid !== 1'b0) begin
      n_bad++;
      $display("FAIL selerr_pulse: got err=%0d credit=%0d state=%0d dv=%0d expected 1/15/1/0",
               sel_err, credit, state, dispense_valid);
    end
    tick();
    n_cmp++;
    if (sel_err !== 1'b0) begin
      n_bad++;
      $display("FAIL selerr_clear: got %0d expected 0", sel_err);
    end
    do_cancel();
    n_cmp++;
    if (state !== 2'd3 || chg_valid !== 1'b1 || credit !== 8'd15) begin
      n_bad++;
      $display("FAIL cancel_enter: got state=%0d chg_valid=%0d credit=%0d expected 3/1/15",
               state, chg_valid, credit);
    end
    exp_q.push_back(2'd1);
    exp_q.push_back(2'd0);
    drain_change("cancel_change", 10);
  endtask

  task automatic test_overflow();
    put_coin(100);
    put_coin(100);
    put_coin(100);
    n_cmp++;
    if (coin_reject !== 1'b1 || credit !== 8'd200) begin
      n_bad++;
      $display("FAIL ovf_reject: got rej=%0d credit=%0d expected 1/200", coin_reject, credit);
    end
    put_coin(7);
    n_cmp++;
    if (coin_reject !== 1'b1 || credit !== 8'd200) begin
      n_bad++;
      $display("FAIL illegal_reject: got rej=%0d credit=%0d expected 1/200", coin_reject, credit);
    end
    tick();
    n_cmp++;
    if (coin_reject !== 1'b0) begin
      n_bad++;
      $display("FAIL reject_clear: got %0d expected 0", coin_reject);
    end
    put_coin(25);
    put_coin(25);
    put_coin(5);
    n_cmp++;
    if (coin_reject !== 1'b0 || credit !== 8'd255) begin
      n_bad++;
      $display("FAIL ceiling_exact: got rej=%0d credit=%0d expected 0/255", coin_reject, credit);
    end
    put_coin(5);
    n_cmp++;
    if (coin_reject !== 1'b1 || credit !== 8'd255) begin
      n_bad++;
      $display("FAIL ceiling_over: got rej=%0d credit=%0d expected 1/255", coin_reject, credit);
    end
    do_cancel();
    push_greedy(255);
    drain_change("ceiling_refund", 20);
  endtask

  task automatic test_stall();
    put_coin(100);
    press(0);
    n_cmp++;
    if (dispense_valid !== 1'b1 || item_dispensed !== 4'd0 || credit !== 8'd85) begin
      n_bad++;
      $display("FAIL stall_disp: got dv=%0d item=%0d credit=%0d expected 1/0/85",
               dispense_valid, item_dispensed, credit);
    end
    tick();
    for (int i = 0; i < 5; i++) begin
      n_cmp++;
      if (chg_valid !== 1'b1 || chg_coin !== 2'd2 || credit !== 8'd85) begin
        n_bad++;
        $display("FAIL stall_hold: got valid=%0d coin=%0d credit=%0d expected 1/2/85",
                 chg_valid, chg_coin, credit);
      end
      tick();
    end
    exp_q.push_back(2'd2);
    exp_q.push_back(2'd2);
    exp_q.push_back(2'd2);
    exp_q.push_back(2'd1);
    drain_change("stall_change", 12);
  endtask

  task automatic test_priority();
    put_coin(25);
    put_coin(25);
    cancel     = 1'b1;
    sel_valid  = 1'b1;
    sel        = 4'd7;
    coin_valid = 1'b1;
    coin_amt   = 8'd25;
    tick();
    cancel     = 1'b0;
    sel_valid  = 1'b0;
    sel        = '0;
    coin_valid = 1'b0;
    coin_amt   = '0;
    n_cmp++;
    if (state !== 2'd3 || coin_reject !== 1'b1 || dispense_valid !== 1'b0 ||
        sel_err !== 1'b0 || credit !== 8'd50) begin
      n_bad++;
      $display("FAIL prio_cancel: got state=%0d rej=%0d dv=%0d err=%0d credit=%0d expected 3/1/0/0/50",
               state, coin_reject, dispense_valid, sel_err, credit);
    end
    exp_q.push_back(2'd2);
    exp_q.push_back(2'd2);
    drain_change("prio_refund", 10);
    cancel     = 1'b1;
    coin_valid = 1'b1;
    coin_amt   = 8'd10;
    tick();
    cancel     = 1'b0;
    coin_valid = 1'b0;
    coin_amt   = '0;
    n_cmp++;
    if (state !== 2'd1 || credit !== 8'd10 || coin_reject !== 1'b0) begin
      n_bad++;
      $display("FAIL idle_cancel_coin: got state=%0d credit=%0d rej=%0d expected 1/10/0",
               state, credit, coin_reject);
    end
    do_cancel();
    exp_q.push_back(2'd1);
    drain_change("idle_cancel_refund", 6);
  endtask

  task automatic test_ignored_and_bad_index();
    put_coin(25);
    do_cancel();
    sel_valid  = 1'b1;
    sel        = 4'd0;
    coin_valid = 1'b1;
    coin_amt   = 8'd5;
    tick();
    sel_valid  = 1'b0;
    coin_valid = 1'b0;
    coin_amt   = '0;
    n_cmp++;
    if (sel_err !== 1'b0 || coin_reject !== 1'b1 || credit !== 8'd25 ||
        state !== 2'd3 || dispense_valid !== 1'b0) begin
      n_bad++;
      $display("FAIL change_ignores: got err=%0d rej=%0d credit=%0d state=%0d dv=%0d expected 0/1/25/3/0",
               sel_err, coin_reject, credit, state, dispense_valid);
    end
    exp_q.push_back(2'd2);
    drain_change("ignore_refund", 6);
    put_coin(25);
    press(9);
    n_cmp++;
    if (sel_err !== 1'b1 || credit !== 8'd25 || state !== 2'd1) begin
      n_bad++;
      $display("FAIL bad_index: got err=%0d credit=%0d state=%0d expected 1/25/1", sel_err, credit, state);
    end
    do_cancel();
    exp_q.push_back(2'd2);
    drain_change("bad_index_refund", 6);
  endtask

  task automatic test_reset_mid_change();
    put_coin(100);
    press(5);
    tick();
    n_cmp++;
    if (state !== 2'd3 || credit !== 8'd60 || chg_valid !== 1'b1) begin
      n_bad++;
      $display("FAIL rst_setup: got state=%0d credit=%0d valid=%0d expected 3/60/1", state, credit, chg_valid);
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    n_cmp++;
    if (state !== 2'd0 || credit !== 8'd0 || chg_valid !== 1'b0) begin
      n_bad++;
      $display("FAIL rst_mid_change: got state=%0d credit=%0d valid=%0d expected 0/0/0", state, credit, chg_valid);
    end
    chg_ready = 1'b1;
    tick();
    tick();
    chg_ready = 1'b0;
    n_cmp++;
    if (chg_valid !== 1'b0 || credit !== 8'd0) begin
      n_bad++;
      $display("FAIL rst_no_more: got valid=%0d credit=%0d expected 0/0", chg_valid, credit);
    end
  endtask

  task automatic test_random();
    int amts[4];
    int mc;
    int n;
    int a;
    int idx;
    int price;
    logic exp_rej;
    amts = '{5, 10, 25, 100};
    for (int it = 0; it < 12; it++) begin
      mc = 0;
      n  = $urandom_range(1, 4);
      for (int k = 0; k < n; k++) begin
        a       = amts[$urandom_range(0, 3)];
        exp_rej = (mc + a > 255);
        put_coin(a);
        if (!exp_rej) mc += a;
        n_cmp++;
        if (coin_reject !== exp_rej || credit !== 8'(mc)) begin
          n_bad++;
          $display("FAIL rnd_coin: got rej=%0d credit=%0d expected %0d/%0d", coin_reject, credit, exp_rej, mc);
        end
      end
      idx   = $urandom_range(0, 7);
      price = 15 + 5 * idx;
      press(idx);
      if (mc >= price) begin
        mc -= price;
        n_cmp++;
        if (dispense_valid !== 1'b1 || item_dispensed !== 4'(idx) || credit !== 8'(mc)) begin
          n_bad++;
          $display("FAIL rnd_disp: got dv=%0d item=%0d credit=%0d expected 1/%0d/%0d",
                   dispense_valid, item_dispensed, credit, idx, mc);
        end
        if (mc > 0) begin
          push_greedy(mc);
          drain_change("rnd_change", 20);
        end else begin
          tick();
          n_cmp++;
          if (state !== 2'd0 || chg_valid !== 1'b0) begin
            n_bad++;
            $display("FAIL rnd_exact: got state=%0d valid=%0d expected 0/0", state, chg_valid);
          end
        end
      end else begin
        n_cmp++;
        if (sel_err !== 1'b1 || credit !== 8'(mc)) begin
          n_bad++;
          $display("FAIL rnd_selerr: got err=%0d credit=%0d expected 1/%0d", sel_err, credit, mc);
        end
        do_cancel();
        push_greedy(mc);
        drain_change("rnd_refund", 20);
      end
    end
  endtask

  initial begin
    rst        = 1'b1;
    coin_valid = 1'b0;
    coin_amt   = '0;
    sel_valid  = 1'b0;
    sel        = '0;
    cancel     = 1'b0;
    chg_ready  = 1'b0;
    test_reset();
    test_dispense();
    test_sel_err();
    test_overflow();
    test_stall();
    test_priority();
    test_ignored_and_bad_index();
    test_reset_mid_change();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/vend_ctrl_param.md
Name: vend_ctrl_param

Overview:
- Parametrised successor to the fixed 8-item vending controller.
- Accepts coins one at a time, with validation and saturation, and accumulates credit.
- On a valid selection with enough credit, dispenses the selected item from a parameter price table.
- Returns change one coin per ready/valid handshake (greedy, largest coin first). Cancel triggers a full refund.
- Sits between the coin/keypad front end and the dispenser/coin-hopper drivers.

Parameters:
- N_ITEMS, 8, number of selectable items (2..16).
- SEL_W, 3, selection width; must satisfy 2**SEL_W >= N_ITEMS.
- AMT_W, 8, credit/amount width in cents.
- MAX_CREDIT, 255, credit ceiling; must be <= 2**AMT_W-1.
- PRICES, packed {50,45,40,35,30,25,20,15} (item0=15 .. item7=50), N_ITEMS*AMT_W bits, item i at bits [i*AMT_W +: AMT_W]. Every price must be a nonzero multiple of 5.

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-high reset
- coin_valid  in  1  coin present this cycle
- coin_amt  in  AMT_W  coin value in cents
- sel_valid  in  1  selection strobe
- sel  in  SEL_W  item index
- cancel  in  1  refund request
- chg_ready  in  1  hopper accepts the offered change coin
- credit  out  AMT_W  current credit
- coin_reject  out  1  1-cycle pulse: coin not accepted
- sel_err  out  1  1-cycle pulse: bad index or insufficient credit
- dispense_valid  out  1  1-cycle pulse: item released
- item_dispensed  out  SEL_W  item index; valid with dispense_valid, else 0
- chg_valid  out  1  change coin offered
- chg_coin  out  2  0=nickel 1=dime 2=quarter 3=dollar
- busy  out  1  high in DISPENSE or CHANGE
- state  out  2  FSM state code, debug only

Behaviour:
- Reset: state=IDLE; credit=0; all pulse outputs 0; chg_valid=0; chg_coin=0; item_dispensed=0. Reset mid-CHANGE abandons the remaining credit; no further coins are offered.
- States: IDLE=0 (credit==0), CREDIT=1, DISPENSE=2, CHANGE=3.
- Coin acceptance:
  - Legal values are 5, 10, 25, 100 only.
  - Accepted in IDLE/CREDIT when credit+coin_amt <= MAX_CREDIT; the sum is computed at AMT_W+1 bits.
  - An accepted coin updates credit the next cycle; IDLE goes to CREDIT.
  - An illegal value, an overflow, or any coin in DISPENSE/CHANGE is not accepted: coin_reject=1 the next cycle, credit unchanged.
- Selection (IDLE/CREDIT):
  - sel >= N_ITEMS, or credit < PRICES[sel]: sel_err pulse next cycle, no state change.
  - Otherwise go to DISPENSE next cycle with credit := credit - price, dispense_valid=1 and item_dispensed=sel for exactly that one cycle.
  - DISPENSE then goes to CHANGE if credit>0, else to IDLE.
  - sel_valid outside IDLE/CREDIT is ignored (no sel_err).
- Cancel: in CREDIT, go to CHANGE with credit intact. Ignored in IDLE, DISPENSE and CHANGE.
- Same-cycle priority (IDLE/CREDIT): cancel > sel_valid > coin_valid. A coin arriving alongside an acted-on cancel or selection is rejected (coin_reject). A coin alongside an ignored cancel (IDLE) is processed normally.
- CHANGE:
  - chg_valid=1 continuously.
  - chg_coin is a combinational greedy pick from credit: >=100 dollar, else >=25 quarter, else >=10 dime, else nickel.
  - On chg_valid&&chg_ready, credit decreases by the coin value that cycle.
  - When credit reaches 0, go to IDLE next cycle with chg_valid=0.
  - chg_valid is held with chg_coin stable while chg_ready=0; no timeout.
- busy=1 in DISPENSE/CHANGE.
- Latency: coin to credit update 1 cycle; sel to dispense_valid 1 cycle; first change coin offered the cycle after DISPENSE or after an acted-on cancel.
- Assertions: PRICES entries multiple of 5; credit always a multiple of 5; chg_coin stable while chg_valid && !chg_ready.

Decomposition:
- Package vend_pkg holds:
  - coin codes COIN_NICKEL..COIN_DOLLAR;
  - function coin_value(code) returning 5/10/25/100;
  - function is_legal_coin(amt);
  - state encodings IDLE/CREDIT/DISPENSE/CHANGE.
- Sub-module change_dispenser: inputs are the remaining credit, chg_ready and an active flag; outputs are chg_valid, chg_coin and the decrement amount. It is the greedy pick plus handshake, instantiated once.

Test Plan:
- Reset with all inputs idle, then coins 25,25 and sel=3 (price 30): credit 25->50; dispense_valid with item 3; credit 20; change dime, dime with chg_ready=1; IDLE after 2 handshakes.
- Coins 5,10 then sel=6 (price 45): sel_err pulse, credit stays 15. Then cancel: change dime then nickel; credit 0.
- Coins 100,100 then coin 100: third coin rejected (200+100 > 255), credit 200. Coin 7 gives coin_reject with credit unchanged.
- Credit 100, sel=0, chg_ready held 0 for 5 cycles: chg_valid=1 with chg_coin=quarter stable. Then ready=1 gives quarters, quarter, quarter, dime, then IDLE (total 85).
- Credit 50 with cancel, sel=7 and coin 25 in the same cycle: refund of 50 (two quarters), no dispense, coin_reject pulse.
- rst asserted during CHANGE with credit 60 remaining: next cycle credit=0, chg_valid=0, state IDLE. sel=9 with N_ITEMS=8, SEL_W=4 gives sel_err.
